// File: rtl/ciclo_temporizador.sv
// ciclo_temporizador: three-phase timed sequencer with a BCD countdown of the
// remaining seconds per phase, feeding the 7-segment decoder stage directly.
module ciclo_temporizador #(
    parameter int DIV  = 50000000,
    parameter int T1   = 30,
    parameter int T2   = 5,
    parameter int T3   = 25,
    parameter int LOOP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic [1:0] estado_out,
    output logic [1:0] dez_out,
    output logic [3:0] unid_out,
    output logic       busy,
    output logic       done
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    localparam logic [1:0] T1_DEZ  = 2'(T1 / 10);
    localparam logic [3:0] T1_UNID = 4'(T1 % 10);
    localparam logic [1:0] T2_DEZ  = 2'(T2 / 10);
    localparam logic [3:0] T2_UNID = 4'(T2 % 10);
    localparam logic [1:0] T3_DEZ  = 2'(T3 / 10);
    localparam logic [3:0] T3_UNID = 4'(T3 % 10);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_F1   = 2'b01,
        S_F2   = 2'b10,
        S_F3   = 2'b11
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [1:0]    dez_q, dez_d;
    logic [3:0]    unid_q, unid_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          done_q, done_d;
    logic          tick;
    logic          run;
    logic          last_sec;

    // Next-state logic: abort beats tick, tick beats start.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        estado_d = estado_q;
        dez_d    = dez_q;
        unid_d   = unid_q;
        pre_d    = pre_q;
        done_d   = 1'b0;

        run      = (estado_q != S_IDLE) && !pause;
        tick     = run && (pre_q == PRE_LAST);
        last_sec = (dez_q == 2'd0) && (unid_q == 4'd1);

        if (abort) begin
            estado_d = S_IDLE;
            dez_d    = 2'd0;
            unid_d   = 4'd0;
            pre_d    = '0;
        end else if (tick) begin
            pre_d = '0;
            if (!last_sec) begin
                if (unid_q != 4'd0) begin
                    unid_d = unid_q - 4'd1;
                end else begin
                    unid_d = 4'd9;
                    dez_d  = dez_q - 2'd1;
                end
            end else begin
                case (estado_q)
                    S_F1: begin
                        estado_d = S_F2;
                        dez_d    = T2_DEZ;
                        unid_d   = T2_UNID;
                    end
                    S_F2: begin
                        estado_d = S_F3;
                        dez_d    = T3_DEZ;
                        unid_d   = T3_UNID;
                    end
                    default: begin
                        done_d = 1'b1;
                        if (LOOP != 0) begin
                            estado_d = S_F1;
                            dez_d    = T1_DEZ;
                            unid_d   = T1_UNID;
                        end else begin
                            estado_d = S_IDLE;
                            dez_d    = 2'd0;
                            unid_d   = 4'd0;
                        end
                    end
                endcase
            end
        end else if (run) begin
            pre_d = pre_q + PW'(1);
        end else if ((estado_q == S_IDLE) && start) begin
            estado_d = S_F1;
            dez_d    = T1_DEZ;
            unid_d   = T1_UNID;
            pre_d    = '0;
        end
    end

    // State, count, prescaler and done registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= S_IDLE;
            dez_q    <= 2'd0;
            unid_q   <= 4'd0;
            pre_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            estado_q <= estado_d;
            dez_q    <= dez_d;
            unid_q   <= unid_d;
            pre_q    <= pre_d;
            done_q   <= done_d;
        end
    end

    assign estado_out = estado_q;
    assign dez_out    = dez_q;
    assign unid_out   = unid_q;
    assign busy       = (estado_q != S_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_ciclo_temporizador.sv
// Directed bench for ciclo_temporizador: three instances with different timing
// parameters, inputs driven and outputs sampled on the falling clock edge.
module tb_ciclo_temporizador;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start_a = 0, pause_a = 0, abort_a = 0;
    logic [1:0] est_a, dez_a;
    logic [3:0] uni_a;
    logic       busy_a, done_a;

    logic       start_b = 0, pause_b = 0, abort_b = 0;
    logic [1:0] est_b, dez_b;
    logic [3:0] uni_b;
    logic       busy_b, done_b;

    logic       start_c = 0, pause_c = 0, abort_c = 0;
    logic [1:0] est_c, dez_c;
    logic [3:0] uni_c;
    logic       busy_c, done_c;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ciclo_temporizador #(.DIV(4), .T1(12), .T2(2), .T3(1), .LOOP(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .pause(pause_a), .abort(abort_a),
        .estado_out(est_a), .dez_out(dez_a), .unid_out(uni_a),
        .busy(busy_a), .done(done_a)
    );

    ciclo_temporizador #(.DIV(4), .T1(3), .T2(2), .T3(1), .LOOP(0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .pause(pause_b), .abort(abort_b),
        .estado_out(est_b), .dez_out(dez_b), .unid_out(uni_b),
        .busy(busy_b), .done(done_b)
    );

    ciclo_temporizador #(.DIV(2), .T1(1), .T2(1), .T3(1), .LOOP(1)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .pause(pause_c), .abort(abort_c),
        .estado_out(est_c), .dez_out(dez_c), .unid_out(uni_c),
        .busy(busy_c), .done(done_c)
    );

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Check all five outputs of instance A against a packed expectation.
    task automatic check_a(input string tag, input int e, input int d, input int u,
                           input int b, input int dn);
        check({tag, ".estado"}, int'(est_a), e);
        check({tag, ".dez"},    int'(dez_a), d);
        check({tag, ".unid"},   int'(uni_a), u);
        check({tag, ".busy"},   int'(busy_a), b);
        check({tag, ".done"},   int'(done_a), dn);
    endtask

    initial begin
        wait_neg(2);
        check_a("reset_a", 0, 0, 0, 0, 0);
        check("reset_b.busy", int'(busy_b), 0);
        check("reset_c.estado", int'(est_c), 0);
        rst = 1'b0;
        wait_neg(2);
        check_a("idle_no_start", 0, 0, 0, 0, 0);

        // BCD borrow on instance A (T1=12, DIV=4).
        start_a = 1'b1;
        wait_neg(1);
        start_a = 1'b0;
        check_a("load_t1", 1, 1, 2, 1, 0);
        wait_neg(3);
        check_a("pre_3clk", 1, 1, 2, 1, 0);
        wait_neg(1);
        check_a("after4", 1, 1, 1, 1, 0);
        wait_neg(4);
        check_a("after8", 1, 1, 0, 1, 0);
        wait_neg(4);
        check_a("after12_borrow", 1, 0, 9, 1, 0);

        // Pause: 2 clocks in, freeze for 10, phase 1 ends 10 clocks late.
        wait_neg(2);
        pause_a = 1'b1;
        wait_neg(10);
        check_a("paused", 1, 0, 9, 1, 0);
        pause_a = 1'b0;
        wait_neg(33);
        check_a("pause_one_before_end", 1, 0, 1, 1, 0);
        wait_neg(1);
        check_a("phase2_load", 2, 0, 2, 1, 0);

        // Start while busy is ignored.
        start_a = 1'b1;
        wait_neg(1);
        start_a = 1'b0;
        check_a("start_busy", 2, 0, 2, 1, 0);
        // Prescaler is now 3: next edge is a tick; abort must win over it.
        wait_neg(2);
        check_a("before_abort", 2, 0, 2, 1, 0);
        abort_a = 1'b1;
        wait_neg(1);
        abort_a = 1'b0;
        check_a("abort_tick", 0, 0, 0, 0, 0);
        wait_neg(5);
        check_a("idle_after_abort", 0, 0, 0, 0, 0);

        // Full cycle on instance B: phases last 12/8/4 clocks.
        start_b = 1'b1;
        wait_neg(1);
        start_b = 1'b0;
        check("b_load.estado", int'(est_b), 1);
        check("b_load.unid", int'(uni_b), 3);
        wait_neg(11);
        check("b_p1_end.estado", int'(est_b), 1);
        check("b_p1_end.unid", int'(uni_b), 1);
        wait_neg(1);
        check("b_p2.estado", int'(est_b), 2);
        check("b_p2.unid", int'(uni_b), 2);
        wait_neg(7);
        check("b_p2_end.estado", int'(est_b), 2);
        wait_neg(1);
        check("b_p3.estado", int'(est_b), 3);
        check("b_p3.unid", int'(uni_b), 1);
        wait_neg(3);
        check("b_p3_end.estado", int'(est_b), 3);
        check("b_p3_end.done", int'(done_b), 0);
        wait_neg(1);
        check("b_exp.estado", int'(est_b), 0);
        check("b_exp.busy", int'(busy_b), 0);
        check("b_exp.done", int'(done_b), 1);
        check("b_exp.unid", int'(uni_b), 0);
        wait_neg(1);
        check("b_done_drop", int'(done_b), 0);
        check("b_idle.estado", int'(est_b), 0);

        // LOOP=1 on instance C: phases advance every 2 clocks, wrap 3->1.
        start_c = 1'b1;
        wait_neg(1);
        start_c = 1'b0;
        check("c_load.estado", int'(est_c), 1);
        for (int i = 0; i < 6; i++) begin
            int exp_e;
            exp_e = (i % 3) + 2;
            if (exp_e == 4) exp_e = 1;
            wait_neg(1);
            check("c_mid.busy", int'(busy_c), 1);
            check("c_mid.done", int'(done_c), 0);
            wait_neg(1);
            check("c_step.estado", int'(est_c), exp_e);
            check("c_step.busy", int'(busy_c), 1);
            check("c_step.done", int'(done_c), (exp_e == 1) ? 1 : 0);
            check("c_step.unid", int'(uni_c), 1);
        end
        abort_c = 1'b1;
        wait_neg(1);
        abort_c = 1'b0;
        check("c_abort.estado", int'(est_c), 0);
        check("c_abort.done", int'(done_c), 0);

        // Asynchronous reset mid-run on instance A, during phase 2.
        start_a = 1'b1;
        wait_neg(1);
        start_a = 1'b0;
        wait_neg(48);
        check_a("rst_pre", 2, 0, 2, 1, 0);
        #2 rst = 1'b1;
        #1;
        check_a("rst_async", 0, 0, 0, 0, 0);
        wait_neg(1);
        rst = 1'b0;
        wait_neg(3);
        check_a("rst_idle", 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ciclo_temporizador.md
Name: ciclo_temporizador

Overview:
Upstream sequencer for the 7-segment display decoder stage. Runs a fixed three-phase timed cycle and counts down each phase's remaining seconds in BCD. Outputs are a 2-bit phase code, a 2-bit tens digit (0–3) and a 4-bit units digit (0–9). All three feed the decoder's state, tens and units inputs directly, with no glue logic.

Parameters:
DIV, 50000000, clock cycles per one-second tick; legal range 2 and above.
T1, 30, phase 1 duration in seconds; legal range 1–39.
T2, 5, phase 2 duration in seconds; legal range 1–39.
T3, 25, phase 3 duration in seconds; legal range 1–39.
LOOP, 0, 0 = return to idle after phase 3; 1 = wrap from phase 3 to phase 1.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level-sampled; begins a cycle when idle
pause  input  1  while high, freezes the prescaler and the count
abort  input  1  returns to idle without asserting done
estado_out  output  2  phase code: 00 idle, 01 phase 1, 10 phase 2, 11 phase 3
dez_out  output  2  tens digit of remaining seconds
unid_out  output  4  units digit of remaining seconds, always 0–9
busy  output  1  high in any non-idle phase
done  output  1  one-cycle pulse at the end of phase 3

Behaviour:
- Reset: while rst is high, every output and internal register is 0 immediately, independent of clk.
  - estado_out=00, dez_out=0, unid_out=0, busy=0, done=0, prescaler=0.
- Loading a phase: the phase's duration T is loaded as BCD, dez=T/10 and unid=T%10. The prescaler clears to 0 on the same edge.
- Prescaler:
  - Increments only when busy=1 and pause=0.
  - tick is an internal signal, high in the cycle where prescaler==DIV-1 and pause=0.
  - The prescaler wraps to 0 on that same edge.
- Priority per edge, highest first:
  1. abort
  2. tick
  3. start
- abort=1:
  - Next state: estado=00, count 00, busy=0, prescaler=0, done=0.
  - Takes effect even in the same cycle as start or a tick.
- IDLE with start=1 and abort=0: next edge gives estado=01, T1 loaded, busy=1.
- start while busy: ignored.
- Countdown on tick, in a running phase:
  - Count > 1: decrement as BCD.
    - unid>0 → unid-1.
    - unid==0 → unid=9, dez-1.
  - Count == 1: advance to the next phase.
    - 01→10 loading T2; 10→11 loading T3.
    - 11 with LOOP=0 → estado=00, count 00, busy=0, done=1 for exactly one cycle.
    - 11 with LOOP=1 → estado=01, T1 loaded, done=1 for one cycle, busy stays 1.
- Display content: a running phase displays T..1 and never 00. Each phase lasts exactly T×DIV clocks, pause time excluded.
- Pause:
  - Holds estado, count and prescaler.
  - On release, counting resumes from the frozen prescaler value.
  - abort still acts while paused.
- done: asserted only on the phase-3 expiry edge and low on the following edge.
- Outputs are registered only. No combinational path from any input to any output.
- Digit range: unid_out never exceeds 9 and dez_out never exceeds 3 in any reachable state.

Test Plan:
1. Reset mid-run: DIV=4, run into phase 2, assert rst between clock edges → all outputs read 0 before the next clk edge; after release, stays idle until start.
2. BCD borrow: DIV=4, T1=12, pulse start.
   - Next edge: estado=01, dez=1, unid=2.
   - After 4 clocks: 11.
   - After 8 clocks: 10.
   - After 12 clocks: dez=0, unid=9.
3. Full cycle: DIV=4, T1=3, T2=2, T3=1, LOOP=0.
   - Phases 01/10/11 last exactly 12/8/4 clocks.
   - Then estado=00, busy=0, with done high for exactly one cycle at 24 clocks after the start edge.
4. Pause: DIV=4, T1=5, assert pause for 10 cycles mid-tick → estado, dez and unid are frozen; the phase ends exactly 10 clocks later than without the pause.
5. Abort and start-while-busy: during phase 2, pulse start → no effect; then assert abort together with a tick → next edge estado=00, count 00, busy=0, done stays 0.
6. LOOP=1: T1=1, T2=1, T3=1, DIV=2 → sequence 01,10,11,01 every 2 clocks, done pulses once per wrap, busy never drops.
